// File: rtl/tick_sequencer.sv
// Sequencer that emits num_ticks one-cycle clock-enable pulses spaced DIVIDE cycles apart,
// with abort, completion pulse and remaining-tick count.
module tick_sequencer #(
    parameter int unsigned DIV_SIM = 4,
    parameter int unsigned DIV_SYN = 50000000,
    parameter int unsigned CW      = 26,
    parameter int unsigned NW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [NW-1:0] num_ticks,
    output logic          tick,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] ticks_left
);

`ifdef SIM
    localparam bit USE_SIM = 1'b1;
`else
    localparam bit USE_SIM = 1'b0;
`endif
    localparam int unsigned DIVIDE = USE_SIM ? DIV_SIM : DIV_SYN;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIVIDE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tick_q, tick_d;
    logic [NW-1:0]   ticks_left_q, ticks_left_d;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            tick_q       <= 1'b0;
            ticks_left_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tick_q       <= tick_d;
            ticks_left_q <= ticks_left_d;
        end
    end

    // Next-state and divider logic; stop always beats start and a coincident wrap
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tick_d       = 1'b0;
        ticks_left_d = ticks_left_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    count_d = '0;
                    if (num_ticks != '0) begin
                        state_d      = RUN;
                        ticks_left_d = num_ticks;
                    end else begin
                        state_d      = DONE;
                        ticks_left_d = '0;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d      = IDLE;
                    count_d      = '0;
                    ticks_left_d = '0;
                end else if (count_q == LAST_COUNT) begin
                    count_d      = '0;
                    tick_d       = 1'b1;
                    ticks_left_d = ticks_left_q - NW'(1);
                    if (ticks_left_q == NW'(1)) begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tick       = tick_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign ticks_left = ticks_left_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: divide-by-4 instance plus a divide-by-1 instance.
module tb_tick_sequencer;

    logic       clk;
    logic       reset;
    logic       start, stop;
    logic [7:0] num_ticks;
    logic       tick, busy, done;
    logic [7:0] ticks_left;
    logic       start1, stop1;
    logic [7:0] num_ticks1;
    logic       tick1, busy1, done1;
    logic [7:0] ticks_left1;

    int checks = 0;
    int errors = 0;

    // Both ratios are pinned so the instances behave the same with or without SIM defined
    tick_sequencer #(.DIV_SIM(4), .DIV_SYN(4), .CW(26), .NW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .num_ticks(num_ticks),
        .tick(tick), .busy(busy), .done(done), .ticks_left(ticks_left)
    );

    tick_sequencer #(.DIV_SIM(1), .DIV_SYN(1), .CW(26), .NW(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1), .num_ticks(num_ticks1),
        .tick(tick1), .busy(busy1), .done(done1), .ticks_left(ticks_left1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic e_tick, input logic e_busy,
                           input logic e_done, input logic [7:0] e_left);
        chk({tag, ".tick"}, k, 32'(tick), 32'(e_tick));
        chk({tag, ".busy"}, k, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, k, 32'(done), 32'(e_done));
        chk({tag, ".left"}, k, 32'(ticks_left), 32'(e_left));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; num_ticks = 8'd0;
        start1 = 1'b0; stop1 = 1'b0; num_ticks1 = 8'd0;

        // Asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset1.busy", 0, 32'(busy1), 32'd0);
        chk("reset1.tick", 0, 32'(tick1), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        chk_all("idle", 0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Three ticks: edges 4, 8, 12 after accept; done with the third
        start = 1'b1; num_ticks = 8'd3;
        for (int k = 0; k <= 13; k++) begin
            step();
            start = 1'b0;
            chk_all("run3", k, (k == 4 || k == 8 || k == 12), (k <= 11), (k == 12),
                    (k < 4) ? 8'd3 : (k < 8) ? 8'd2 : (k < 12) ? 8'd1 : 8'd0);
        end

        // Zero ticks: immediate one-cycle done; start held through DONE is ignored
        start = 1'b1; num_ticks = 8'd0;
        step();
        chk_all("zero", 0, 1'b0, 1'b0, 1'b1, 8'd0);
        step();
        start = 1'b0;
        chk_all("zero", 1, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        chk_all("zero", 2, 1'b0, 1'b0, 1'b0, 8'd0);

        // Stop in the cycle after edge 6 of a five-tick run
        start = 1'b1; num_ticks = 8'd5;
        for (int k = 0; k <= 8; k++) begin
            step();
            start = 1'b0;
            chk_all("stop5", k, (k == 4), (k <= 6), 1'b0,
                    (k < 4) ? 8'd5 : (k <= 6) ? 8'd4 : 8'd0);
            stop = (k == 6);
        end
        stop = 1'b0;

        // Start together with stop in IDLE: stays IDLE
        start = 1'b1; stop = 1'b1; num_ticks = 8'd7;
        step();
        chk_all("startstop", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b0; stop = 1'b0;
        step();
        chk_all("startstop", 1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Start re-pulsed with a new count during RUN has no effect
        start = 1'b1; num_ticks = 8'd2;
        for (int k = 0; k <= 9; k++) begin
            step();
            start = (k == 1);
            num_ticks = (k == 1) ? 8'd9 : 8'd2;
            chk_all("restart", k, (k == 4 || k == 8), (k <= 7), (k == 8),
                    (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0);
        end
        start = 1'b0;

        // Stop coincident with the first wrap edge suppresses the tick
        start = 1'b1; num_ticks = 8'd2;
        for (int k = 0; k <= 5; k++) begin
            step();
            start = 1'b0;
            chk_all("stopwrap", k, 1'b0, (k <= 3), 1'b0, (k <= 3) ? 8'd2 : 8'd0);
            stop = (k == 3);
        end
        stop = 1'b0;

        // Reset mid-RUN clears everything without a clock; next start is clean
        start = 1'b1; num_ticks = 8'd3;
        for (int k = 0; k <= 5; k++) begin
            step();
            start = 1'b0;
        end
        chk_all("prereset", 5, 1'b0, 1'b1, 1'b0, 8'd2);
        #2 reset = 1'b1;
        #1;
        chk_all("midreset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        step();
        reset = 1'b0;
        chk_all("midreset", 1, 1'b0, 1'b0, 1'b0, 8'd0);
        start = 1'b1; num_ticks = 8'd1;
        for (int k = 0; k <= 5; k++) begin
            step();
            start = 1'b0;
            chk_all("afterreset", k, (k == 4), (k <= 3), (k == 4), (k < 4) ? 8'd1 : 8'd0);
        end

        // Divide-by-1 instance: 255 consecutive ticks, done with the last
        start1 = 1'b1; num_ticks1 = 8'd255;
        for (int k = 0; k <= 256; k++) begin
            step();
            start1 = 1'b0;
            chk("div1.tick", k, 32'(tick1), 32'(k >= 1 && k <= 255));
            chk("div1.busy", k, 32'(busy1), 32'(k < 255));
            chk("div1.done", k, 32'(done1), 32'(k == 255));
            chk("div1.left", k, 32'(ticks_left1), (k == 0) ? 32'd255 : (k <= 255) ? 32'(255 - k) : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 SHALL have parameter DIV_SIM, default 4, divide ratio used when compiler symbol SIM is defined (simulation).
REQ-002 SHALL have parameter DIV_SYN, default 50000000, divide ratio used when SIM is undefined (synthesis).
REQ-003 SHALL have parameter CW, default 26, divider counter width.
REQ-004 SHALL have parameter NW, default 8, tick-count width.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a tick sequence; sampled only in IDLE.
REQ-008 SHALL have port stop  input  1  abort current sequence.
REQ-009 SHALL have port num_ticks  input  NW  number of ticks to emit; latched on accepted start.
REQ-010 SHALL have port tick  output  1  one-cycle clock-enable pulse.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port ticks_left  output  NW  ticks remaining in current sequence.

Function
REQ-014 SHALL select internal ratio DIVIDE = DIV_SIM under `ifdef SIM, else DIV_SYN; no other source of the ratio.
REQ-015 SHALL require 1 <= DIVIDE <= 2^CW - 1; out-of-range values are unsupported.
REQ-016 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE); all other outputs registered.
REQ-017 IDLE, start=1, stop=0, num_ticks!=0: next edge -> RUN, ticks_left<=num_ticks, divider count<=0.
REQ-018 IDLE, start=1, stop=0, num_ticks==0: next edge -> DONE, no tick emitted.
REQ-019 IDLE, start=1 and stop=1 same cycle: stop wins, remain IDLE.
REQ-020 RUN, each edge: count==DIVIDE-1 -> count<=0, tick<=1, ticks_left<=ticks_left-1; otherwise count<=count+1, tick<=0.
REQ-021 First tick SHALL be high in the cycle following the DIVIDE-th edge after the start-accepting edge; subsequent ticks every DIVIDE cycles.
REQ-022 RUN, wrap edge with ticks_left==1: tick<=1, ticks_left<=0, state<=DONE; final tick and done are high in the same cycle.
REQ-023 DONE SHALL last exactly one cycle then return to IDLE; start during DONE ignored.
REQ-024 RUN, stop=1: next edge -> IDLE, tick<=0, ticks_left<=0, count<=0, no done pulse; stop overrides a coincident wrap.
REQ-025 start during RUN SHALL be ignored; num_ticks changes during RUN SHALL have no effect.
REQ-026 stop in IDLE or DONE SHALL have no effect other than REQ-019.
REQ-027 DIVIDE==1: tick high every cycle of RUN, first tick in cycle after first RUN edge.
REQ-028 tick SHALL be 0 in IDLE and whenever not asserted by REQ-020/022.

Reset
REQ-029 reset=1 SHALL immediately (no clock) force state=IDLE, count=0, tick=0, busy=0, done=0, ticks_left=0.
REQ-030 reset asserted mid-RUN SHALL abort without done; first start after release is handled per REQ-017.

Verification (bench compiled with SIM defined, DIV_SIM=4)
REQ-031 Reset mid-RUN at arbitrary cycle -> tick, busy, done, ticks_left all 0 before next clk edge.
REQ-032 start with num_ticks=3 -> tick high in cycles after edges 4, 8, 12 relative to accept edge; ticks_left 3,2,1,0; done coincident with third tick; busy high 12 cycles.
REQ-033 start with num_ticks=0 -> done high for one cycle after accept edge, tick never high, busy never high.
REQ-034 start num_ticks=5, stop asserted in cycle after edge 6 -> exactly one tick (after edge 4), IDLE next edge, ticks_left=0, no done.
REQ-035 start pulsed during RUN and start+stop together in IDLE -> no restart, no state change, ticks_left unchanged.
REQ-036 DIV_SIM overridden to 1, num_ticks=255 -> 255 consecutive tick cycles, ticks_left 255..0, done with last tick.
